// File: rtl/demux_stream_pkg.sv
// Shared constants and types for the 1-to-N stream demultiplexer.
// Holds counter width, slot state encoding and legal channel range.
package demux_stream_pkg;

    localparam int STAT_W     = 16;
    localparam int NUM_CH_MIN = 2;
    localparam int NUM_CH_MAX = 16;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/demux_stream_slot.sv
// One output slot: 1-entry buffer with valid/ready drain side.
// Ports: load/wdata (fill), ready (consumer), valid/data (slot), cnt.
// Data reads zero whenever the slot is empty.
// Beat counter exists only when DEMUX_STREAM_STAT_EN is defined.
module demux_stream_slot
    import demux_stream_pkg::*;
#(
    parameter int BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [BUS_WIDTH-1:0] wdata,
    input  logic                 ready,
    output logic                 valid,
    output logic [BUS_WIDTH-1:0] data,
    output logic [STAT_W-1:0]    cnt
);

    slot_state_e          state_q, state_d;
    logic [BUS_WIDTH-1:0] data_q;
    logic                 drain;

    assign valid = (state_q == SLOT_FULL);
    assign drain = valid & ready;
    assign data  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= SLOT_EMPTY;
        else        state_q <= state_d;
    end

    // load while FULL can only happen together with a drain,
    // because the top gates acceptance on !valid | ready
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SLOT_EMPTY: if (load)           state_d = SLOT_FULL;
            SLOT_FULL:  if (drain && !load) state_d = SLOT_EMPTY;
            default:                        state_d = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     data_q <= '0;
        else if (load)  data_q <= wdata;
        else if (drain) data_q <= '0;
    end

`ifdef DEMUX_STREAM_STAT_EN
    logic [STAT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (drain && cnt_q != '1)
            cnt_q <= cnt_q + 1'b1;
    end

    assign cnt = cnt_q;
`else
    assign cnt = '0;
`endif

endmodule

// File: rtl/demux_stream_nch.sv
// Registered 1-to-NUM_CH stream demux with per-channel 1-entry slots.
// Ports: in_* (producer), out_* (per-channel), sel_err, stat_cnt.
// Optional per-channel beat counters: define DEMUX_STREAM_STAT_EN.
module demux_stream_nch
    import demux_stream_pkg::*;
#(
    parameter int BUS_WIDTH = 8,
    parameter int NUM_CH    = 4,
    parameter int SEL_W     = $clog2(NUM_CH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BUS_WIDTH-1:0]        in_data,
    input  logic [SEL_W-1:0]            in_sel,
    output logic [NUM_CH-1:0]           out_valid,
    input  logic [NUM_CH-1:0]           out_ready,
    output logic [NUM_CH*BUS_WIDTH-1:0] out_data,
    output logic                        sel_err,
    output logic [NUM_CH*STAT_W-1:0]    stat_cnt
);

    if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_bad_nch
        $error("demux_stream_nch: NUM_CH out of range");
    end
    if (SEL_W != $clog2(NUM_CH)) begin : g_bad_selw
        $error("demux_stream_nch: SEL_W must not be overridden");
    end

    logic              sel_ok;
    logic              accept;
    logic              rdy_mux;
    logic [NUM_CH-1:0] load;
    logic              sel_err_q;

    assign sel_ok = 32'(in_sel) < NUM_CH;

    // out-of-range selects are always accepted and dropped
    always_comb begin
        rdy_mux = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (in_sel == SEL_W'(k))
                rdy_mux = !out_valid[k] | out_ready[k];
        end
    end

    assign in_ready = rdy_mux;
    assign accept   = in_valid & in_ready;

    always_comb begin
        load = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            load[k] = accept & (in_sel == SEL_W'(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sel_err_q <= 1'b0;
        else        sel_err_q <= accept & !sel_ok;
    end

    assign sel_err = sel_err_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_stream_slot #(
            .BUS_WIDTH(BUS_WIDTH)
        ) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[k]),
            .wdata (in_data),
            .ready (out_ready[k]),
            .valid (out_valid[k]),
            .data  (out_data[k*BUS_WIDTH +: BUS_WIDTH]),
            .cnt   (stat_cnt[k*STAT_W +: STAT_W])
        );
    end

endmodule

// File: tb/tb_demux_stream_nch.sv
// Directed bench for demux_stream_nch (4-channel and 5-channel builds).
// Table-driven vectors plus hand sequences for reset, sel_err, counters.
module tb_demux_stream_nch;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic        sel_err;
    logic [63:0] stat_cnt;

    logic        in_valid5;
    logic        in_ready5;
    logic [7:0]  in_data5;
    logic [2:0]  in_sel5;
    logic [4:0]  out_valid5;
    logic [4:0]  out_ready5;
    logic [39:0] out_data5;
    logic        sel_err5;
    logic [79:0] stat_cnt5;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    demux_stream_nch #(.BUS_WIDTH(8), .NUM_CH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sel_err   (sel_err),
        .stat_cnt  (stat_cnt)
    );

    demux_stream_nch #(.BUS_WIDTH(8), .NUM_CH(5)) dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .in_data   (in_data5),
        .in_sel    (in_sel5),
        .out_valid (out_valid5),
        .out_ready (out_ready5),
        .out_data  (out_data5),
        .sel_err   (sel_err5),
        .stat_cnt  (stat_cnt5)
    );

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic [7:0]  d;
        logic [3:0]  rdy;
        logic        irdy;
        logic [3:0]  ov;
        logic [31:0] od;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [79:0] act,
                       input logic [79:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 2'd0, 8'h11, 4'hF, 1'b1, 4'b0001, 32'h0000_0011};
        tbl[1]  = '{1'b1, 2'd1, 8'h22, 4'hF, 1'b1, 4'b0010, 32'h0000_2200};
        tbl[2]  = '{1'b1, 2'd2, 8'h33, 4'hF, 1'b1, 4'b0100, 32'h0033_0000};
        tbl[3]  = '{1'b1, 2'd3, 8'h44, 4'hF, 1'b1, 4'b1000, 32'h4400_0000};
        tbl[4]  = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h0000_0000};
        tbl[5]  = '{1'b1, 2'd2, 8'hA5, 4'hB, 1'b1, 4'b0100, 32'h00A5_0000};
        tbl[6]  = '{1'b1, 2'd1, 8'h77, 4'hB, 1'b1, 4'b0110, 32'h00A5_7700};
        tbl[7]  = '{1'b0, 2'd0, 8'h00, 4'hB, 1'b1, 4'b0100, 32'h00A5_0000};
        tbl[8]  = '{1'b1, 2'd2, 8'h5A, 4'hB, 1'b0, 4'b0100, 32'h00A5_0000};
        tbl[9]  = '{1'b1, 2'd2, 8'h5A, 4'hB, 1'b0, 4'b0100, 32'h00A5_0000};
        tbl[10] = '{1'b1, 2'd2, 8'h5A, 4'hF, 1'b1, 4'b0100, 32'h005A_0000};
        tbl[11] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h0000_0000};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_sel     = '0;
        out_ready  = '0;
        in_valid5  = 1'b0;
        in_data5   = '0;
        in_sel5    = '0;
        out_ready5 = '0;
        repeat (3) @(negedge clk);

        chk("rst_out_valid", 80'(out_valid), 80'(0));
        chk("rst_out_data", 80'(out_data), 80'(0));
        chk("rst_sel_err", 80'(sel_err), 80'(0));
        chk("rst_stat_cnt", 80'(stat_cnt), 80'(0));
        chk("rst_in_ready", 80'(in_ready), 80'(1));
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_valid  = tbl[i].v;
            in_sel    = tbl[i].sel;
            in_data   = tbl[i].d;
            out_ready = tbl[i].rdy;
            #1;
            chk($sformatf("v%0d_in_ready", i), 80'(in_ready),
                80'(tbl[i].irdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), 80'(out_valid),
                80'(tbl[i].ov));
            chk($sformatf("v%0d_out_data", i), 80'(out_data),
                80'(tbl[i].od));
        end

        // 5-channel build: highest legal channel, then invalid select
        @(negedge clk);
        in_valid5  = 1'b1;
        in_sel5    = 3'd4;
        in_data5   = 8'h44;
        out_ready5 = 5'b0_0000;
        @(posedge clk);
        #1;
        chk("ch4_out_valid", 80'(out_valid5), 80'(5'b1_0000));
        chk("ch4_out_data", 80'(out_data5), 80'(40'h44_0000_0000));
        @(negedge clk);
        in_sel5    = 3'd6;
        in_data5   = 8'hFF;
        out_ready5 = 5'b1_1111;
        #1;
        chk("bad_sel_in_ready", 80'(in_ready5), 80'(1));
        @(posedge clk);
        #1;
        chk("bad_sel_err_hi", 80'(sel_err5), 80'(1));
        chk("bad_sel_out_valid", 80'(out_valid5), 80'(0));
        chk("bad_sel_out_data", 80'(out_data5), 80'(0));
        @(negedge clk);
        in_valid5 = 1'b0;
        @(posedge clk);
        #1;
        chk("bad_sel_err_lo", 80'(sel_err5), 80'(0));
        chk("sel_err_4ch_idle", 80'(sel_err), 80'(0));

        // back-to-back beats into ch0, no bubbles
        out_ready = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_sel   = 2'd0;
            in_data  = 8'(8'h80 + i);
            #1;
            chk($sformatf("stream%0d_in_ready", i), 80'(in_ready),
                80'(1));
            @(posedge clk);
            #1;
            chk($sformatf("stream%0d_valid", i), 80'(out_valid),
                80'(4'b0001));
            chk($sformatf("stream%0d_data", i), 80'(out_data),
                80'(32'h80 + i));
        end

        // asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 80'(out_valid), 80'(0));
        chk("async_rst_data", 80'(out_data), 80'(0));
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_valid", 80'(out_valid), 80'(0));

        // three handshakes on ch1 with ch1 stalled between beats
        out_ready = 4'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_sel    = 2'd1;
            in_data   = 8'(i + 1);
            out_ready = 4'h0;
            @(posedge clk);
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 4'b0010;
            @(posedge clk);
        end
        @(negedge clk);
        out_ready = 4'h0;
`ifdef DEMUX_STREAM_STAT_EN
        chk("stat_ch1_three", 80'(stat_cnt[31:16]), 80'(3));
`else
        chk("stat_ch1_off", 80'(stat_cnt[31:16]), 80'(0));
`endif

        // saturating counter on ch3
        out_ready = 4'hF;
        in_valid  = 1'b1;
        in_sel    = 2'd3;
        in_data   = 8'h3C;
        repeat (70000) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("stat_drained_valid", 80'(out_valid), 80'(0));
`ifdef DEMUX_STREAM_STAT_EN
        chk("stat_ch3_sat", 80'(stat_cnt[63:48]), 80'(16'hFFFF));
        chk("stat_ch0_zero", 80'(stat_cnt[15:0]), 80'(0));
        chk("stat_ch1_kept", 80'(stat_cnt[31:16]), 80'(3));
        chk("stat_ch2_zero", 80'(stat_cnt[47:32]), 80'(0));
`else
        chk("stat_all_zero", 80'(stat_cnt), 80'(0));
        chk("stat5_all_zero", 80'(stat_cnt5), 80'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
